resp_sched_bridge: RTL
======================

Name: resp_sched_bridge

Overview:
- Per-slave response scheduler in front of the bridge response fan-in tree.
- The tree merges N_SLAVE response channels combinationally and is correct only when at most one input valid is high per cycle.
- This block buffers one response per slave and grants the tree to one slave per cycle, round-robin.
- It drives a one-hot valid vector and back-pressures slaves through a per-slave grant.

Parameters:
N_SLAVE, 16, number of response sources; any value >= 1 (the tree itself needs a power of 2)
DATA_WIDTH, 32, response data width
AUX_WIDTH, 8, auxiliary/ID field width
PTR_W, max(1,$clog2(N_SLAVE)), derived localparam, round-robin pointer width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
slv_r_valid_i  in  N_SLAVE  response valid per slave
slv_r_rdata_i  in  N_SLAVE x DATA_WIDTH  response data per slave
slv_r_opc_i  in  N_SLAVE  response opcode/error bit per slave
slv_r_aux_i  in  N_SLAVE x AUX_WIDTH  aux per slave
slv_r_gnt_o  out  N_SLAVE  slot can accept this cycle
data_r_valid_o  out  N_SLAVE  to tree, one-hot or zero
data_r_rdata_o  out  N_SLAVE x DATA_WIDTH  to tree, held slot data
data_r_opc_o  out  N_SLAVE  to tree
data_r_aux_o  out  N_SLAVE x AUX_WIDTH  to tree
data_r_ready_i  in  1  downstream accepts the tree output this cycle
overflow_o  out  1  sticky error: valid seen while grant low

Behaviour:
- State per slave i: full_q[i], plus payload registers rdata_q/opc_q/aux_q. Global state: rr_ptr_q (PTR_W bits) and ovf_q.
- Reset (synchronous, rst_n=0 at clk edge): full_q=0, rr_ptr_q=0, ovf_q=0. Payload registers are not reset.
- Outputs during and after reset: data_r_valid_o=0, slv_r_gnt_o=all 1, overflow_o=0.
- Arbitration is combinational over full_q. Winner w is the first i with full_q[i]=1 scanning rr_ptr_q, rr_ptr_q+1, … and wrapping from N_SLAVE-1 to 0.
- data_r_valid_o[i] = full_q[i] & (i==w). No valid when no slot is full. The valid does not depend on data_r_ready_i.
- data_r_rdata_o/opc_o/aux_o[i] = payload registers of slot i, driven for every i.
- pop[i] = data_r_valid_o[i] & data_r_ready_i.
- On a pop of w: rr_ptr_q <= (w==N_SLAVE-1) ? 0 : w+1. Without a pop, rr_ptr_q holds.
- slv_r_gnt_o[i] = ~full_q[i] | pop[i]. Same-cycle pop and refill are allowed, giving 1 response per cycle per slave at full rate. The data_r_ready_i→gnt combinational path is accepted.
- Accept: slv_r_valid_i[i] & slv_r_gnt_o[i] loads the payload and sets full_q[i]=1. A pop without an accept clears full_q[i].
- Latency: a response accepted in cycle t appears at the tree input in cycle t+1 at the earliest.
- Fairness: a full slot waits at most N_SLAVE-1 pops of other slots.
- Overflow: slv_r_valid_i[i] & ~slv_r_gnt_o[i] sets ovf_q. The response is dropped and the slot is unchanged. ovf_q clears only on reset.
- N_SLAVE=1: the pointer stays 0, and valid = full_q[0].
- data_r_ready_i=0: all state holds. The valid stays high on the same winner because the pointer does not move.
- Reset mid-operation: buffered responses are discarded. The first post-reset cycle shows no valid.

Decomposition:
- No shared package needed. Widths come from parameters; the overflow flag is the only status.
- One natural sub-module: rr_arb_bridge (N parameter).
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], winner index.
  - Purely combinational.
- Slot registers and the pointer update live in resp_sched_bridge.

Test Plan (all scenarios use N_SLAVE=4, data_r_ready_i=1 unless stated):
1. Single response: slave 2 sends rdata=0xA5A5_0002, aux=0x12 at t → data_r_valid_o=4'b0100 at t+1 with that data; full cleared at t+2; rr_ptr=3.
2. All four valid in the same cycle at t, ptr=0 → valids 0001,0010,0100,1000 at t+1..t+4; never two bits high; ptr returns to 0.
3. Back-pressure: ready=0 for 5 cycles with slots 1 and 3 full → valid holds 0010 with stable data, gnt=4'b0101, no pop; ready=1 → slot 1 pops, then slot 3.
4. Streaming: slave 0 valid every cycle with incrementing data 0..9, others idle → one pop per cycle, data in order 0..9, gnt[0] stays 1, no overflow.
5. Overflow: ready=0, slave 1 full, slave 1 asserts valid again with 0xDEAD → overflow_o=1 next cycle; later pop delivers the original data, not 0xDEAD; overflow stays 1 until reset.
6. Reset mid-operation: slots 0–3 full, rst_n=0 for one edge → next cycle data_r_valid_o=0, gnt=4'b1111, overflow_o=0, ptr=0.

Source files
------------

// File: rtl/rr_arb_bridge.sv
// Round-robin arbiter: picks the first requesting index at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arb_bridge #(
  parameter  int N     = 16,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] winner
);

  logic found;

  // Scan from ptr upwards with wrap-around; the first request seen wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (int'(ptr) + j) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        winner      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/resp_sched_bridge.sv
// Per-slave response scheduler: buffers one response per slave and hands the
// fan-in tree at most one valid per cycle, round-robin across full slots.
module resp_sched_bridge #(
  parameter  int N_SLAVE    = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  int AUX_WIDTH  = 8,
  localparam int PTR_W      = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_SLAVE-1:0]                  slv_r_valid_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  slv_r_rdata_i,
  input  logic [N_SLAVE-1:0]                  slv_r_opc_i,
  input  logic [N_SLAVE-1:0][AUX_WIDTH-1:0]   slv_r_aux_i,
  output logic [N_SLAVE-1:0]                  slv_r_gnt_o,
  output logic [N_SLAVE-1:0]                  data_r_valid_o,
  output logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  data_r_rdata_o,
  output logic [N_SLAVE-1:0]                  data_r_opc_o,
  output logic [N_SLAVE-1:0][AUX_WIDTH-1:0]   data_r_aux_o,
  input  logic                                data_r_ready_i,
  output logic                                overflow_o
);

  logic [N_SLAVE-1:0]                 full_q;
  logic [N_SLAVE-1:0][DATA_WIDTH-1:0] rdata_q;
  logic [N_SLAVE-1:0]                 opc_q;
  logic [N_SLAVE-1:0][AUX_WIDTH-1:0]  aux_q;
  logic [PTR_W-1:0]                   rr_ptr_q;
  logic                               ovf_q;

  logic [N_SLAVE-1:0] arb_gnt;
  logic [PTR_W-1:0]   winner;
  logic [N_SLAVE-1:0] pop;
  logic [N_SLAVE-1:0] accept;
  logic               drop;

  rr_arb_bridge #(.N(N_SLAVE)) u_arb (
    .req    (full_q),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .winner (winner)
  );

  // Handshake decode: the arbiter grant is the tree valid (zero when no slot
  // is full); a popped slot can be refilled in the same cycle.
  always_comb begin
    data_r_valid_o = arb_gnt;
    pop            = arb_gnt & {N_SLAVE{data_r_ready_i}};
    slv_r_gnt_o    = ~full_q | pop;
    accept         = slv_r_valid_i & slv_r_gnt_o;
    drop           = |(slv_r_valid_i & ~slv_r_gnt_o);
    data_r_rdata_o = rdata_q;
    data_r_opc_o   = opc_q;
    data_r_aux_o   = aux_q;
    overflow_o     = ovf_q;
  end

  // Control state: slot occupancy, round-robin pointer and sticky overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q   <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_SLAVE; i++) begin
        if (accept[i])   full_q[i] <= 1'b1;
        else if (pop[i]) full_q[i] <= 1'b0;
      end
      if (|pop) begin
        rr_ptr_q <= (winner == PTR_W'(N_SLAVE - 1)) ? '0 : winner + 1'b1;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Payload capture on accept only; dropped responses never touch a slot.
  // NOTE: payload registers carry no reset: full_q gates their use, so
  // resetting them would only add reset fan-out to a wide datapath.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SLAVE; i++) begin
      if (accept[i]) begin
        rdata_q[i] <= slv_r_rdata_i[i];
        opc_q[i]   <= slv_r_opc_i[i];
        aux_q[i]   <= slv_r_aux_i[i];
      end
    end
  end

endmodule
